// File: rtl/cobertura_ctrl.sv
// cobertura_ctrl: motorised roof/cover controller.
//   Synchronises the L/U sensors and the Fd/Fe end-stops. L and U are also
//   debounced. The block then drives the motor open (A) or closed (F), with a
//   dead time between drives, a travel timeout and a latched fault state.
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   L, U                   light / rain sensors (async pins)
//   Fd, Fe                 open / closed end-stops (async pins)
//   clr_falha              synchronous fault clear pulse
//   man_en, man_abrir, man_fechar
//                          manual override, present only with COBERTURA_MANUAL_EN
//   A, F                   motor drive open / close
//   estado                 state: 0 PARADO, 1 ABRINDO, 2 FECHANDO, 3 FALHA
//   falha                  high while in FALHA
// Build option: define COBERTURA_MANUAL_EN to add the manual override inputs.
module cobertura_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned DEADTIME_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       L,
  input  logic       U,
  input  logic       Fd,
  input  logic       Fe,
  input  logic       clr_falha,
`ifdef COBERTURA_MANUAL_EN
  input  logic       man_en,
  input  logic       man_abrir,
  input  logic       man_fechar,
`endif
  output logic       A,
  output logic       F,
  output logic [1:0] estado,
  output logic       falha
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TM_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DT_W = (DEADTIME_CYCLES == 0) ? 1 : $clog2(DEADTIME_CYCLES + 1);
`ifdef COBERTURA_MANUAL_EN
  localparam int unsigned NSYNC = 7;
`else
  localparam int unsigned NSYNC = 4;
`endif

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ABRINDO  = 2'd1,
    FECHANDO = 2'd2,
    FALHA    = 2'd3
  } state_t;

  logic [NSYNC-1:0]       meta_q, meta_d, sync_q, sync_d;
  logic [1:0]             filt_q, filt_d;
  logic [1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [TM_W-1:0]        tm_cnt_q, tm_cnt_d;
  logic [DT_W-1:0]        dt_cnt_q, dt_cnt_d;
  state_t                 state_q, state_d;
  logic                   fd_s, fe_s, lf, uf;
  logic                   req_abrir, req_fechar;

  // Two-flop synchroniser; bit order {man..., Fe, Fd, U, L}.
  always_comb begin
`ifdef COBERTURA_MANUAL_EN
    meta_d = {man_fechar, man_abrir, man_en, Fe, Fd, U, L};
`else
    meta_d = {Fe, Fd, U, L};
`endif
    sync_d = meta_q;
  end

  assign fd_s = sync_q[2];
  assign fe_s = sync_q[3];
  assign lf   = filt_q[0];
  assign uf   = filt_q[1];

  // Debounce L/U: the filtered value follows only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Request selection; both manual buttons together cancel each other.
  always_comb begin
    req_fechar = lf | uf;
    req_abrir  = ~lf & ~uf;
`ifdef COBERTURA_MANUAL_EN
    if (sync_q[4]) begin
      req_abrir  = sync_q[5] & ~sync_q[6];
      req_fechar = sync_q[6] & ~sync_q[5];
    end
`endif
  end

  // Next state and counters.
  always_comb begin
    state_d  = state_q;
    tm_cnt_d = tm_cnt_q;
    dt_cnt_d = dt_cnt_q;
    unique case (state_q)
      PARADO: begin
        if (dt_cnt_q < DT_W'(DEADTIME_CYCLES)) begin
          dt_cnt_d = dt_cnt_q + DT_W'(1);
        end else if (req_fechar && !fe_s) begin
          state_d = FECHANDO;
        end else if (req_abrir && !fd_s) begin
          state_d = ABRINDO;
        end
      end
      ABRINDO: begin
        tm_cnt_d = tm_cnt_q + TM_W'(1);
        if (fd_s || req_fechar) begin
          state_d = PARADO;
        end else if (tm_cnt_q == TM_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = FALHA;
        end
      end
      FECHANDO: begin
        tm_cnt_d = tm_cnt_q + TM_W'(1);
        if (fe_s || req_abrir) begin
          state_d = PARADO;
        end else if (tm_cnt_q == TM_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = FALHA;
        end
      end
      FALHA: begin
        if (clr_falha) begin
          state_d = PARADO;
        end
      end
      default: state_d = PARADO;
    endcase
    // Both end-stops active at once is physically impossible: fault first.
    if (state_q != FALHA && fd_s && fe_s) begin
      state_d = FALHA;
    end
    // Entry actions: fresh travel timer, fresh dead time on every stop.
    if (state_d != state_q) begin
      tm_cnt_d = '0;
      if (state_d == PARADO) begin
        dt_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      filt_q   <= '0;
      db_cnt_q <= '0;
      tm_cnt_q <= '0;
      dt_cnt_q <= DT_W'(DEADTIME_CYCLES);
      state_q  <= PARADO;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
      tm_cnt_q <= tm_cnt_d;
      dt_cnt_q <= dt_cnt_d;
      state_q  <= state_d;
    end
  end

  // Outputs decoded from the state flop, so reset drops them at once.
  assign A      = (state_q == ABRINDO);
  assign F      = (state_q == FECHANDO);
  assign falha  = (state_q == FALHA);
  assign estado = state_q;

endmodule
